// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU types (opcodes, flags) and arbiter FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_ARB_MAX_REQ = 4;

    // Codes 5..7 are undefined and yield a zero result with only Z set.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : Alu
// Description : 32-bit combinational ALU producing a result and N/Z/C/V flags.
// Revision    : 1.0 - initial release
// ============================================================================
module Alu
    import alu_pkg::*;
(
    input  alu_op_t     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output alu_flags_t  o_flags
);

    logic [32:0] w_sum;
    logic [31:0] w_res;
    logic        w_c;
    logic        w_v;

    always_comb begin
        w_sum = 33'd0;
        w_res = 32'd0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum = {1'b0, i_a} + {1'b0, i_b};
                w_res = w_sum[31:0];
                w_c   = w_sum[32];
                w_v   = (i_a[31] == i_b[31]) && (w_res[31] != i_a[31]);
            end
            OP_SUB: begin
                // Carry out of a + ~b + 1 is the not-borrow flag.
                w_sum = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
                w_res = w_sum[31:0];
                w_c   = w_sum[32];
                w_v   = (i_a[31] != i_b[31]) && (w_res[31] != i_a[31]);
            end
            OP_AND:  w_res = i_a & i_b;
            OP_OR:   w_res = i_a | i_b;
            OP_XOR:  w_res = i_a ^ i_b;
            default: w_res = 32'd0;
        endcase
    end

    assign o_result  = w_res;
    assign o_flags.n = w_res[31];
    assign o_flags.z = (w_res == 32'd0);
    assign o_flags.c = w_c;
    assign o_flags.v = w_v;

endmodule : Alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one ALU among NUM_REQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  alu_op_t [NUM_REQ-1:0]        req_opcode,
    input  logic [NUM_REQ-1:0][31:0]     req_a,
    input  logic [NUM_REQ-1:0][31:0]     req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [31:0]                  rsp_data,
    output alu_flags_t                   rsp_flags,
    output alu_flags_t                   apsr_flags
);

    arb_state_t        r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_cur_id;
    alu_op_t           r_op;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [31:0]       r_rsp_data;
    alu_flags_t        r_rsp_flags;
    alu_flags_t        r_apsr;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_any;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_cand;
    logic [ID_W-1:0]    w_next_ptr;
    logic [31:0]        w_result;
    alu_flags_t         w_flags;

    // Grant only in IDLE and never while reset is asserted.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        if (r_state == IDLE && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_cand = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                if (!w_any && req_valid[w_cand]) begin
                    w_any = 1'b1;
                    w_idx = w_cand;
                end
            end
        end
        if (w_any) begin
            w_grant[w_idx] = 1'b1;
        end
        w_next_ptr = ID_W'((int'(w_idx) + 1) % NUM_REQ);
    end

    assign req_ready = w_grant;

    Alu u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_cur_id    <= '0;
            r_op        <= OP_ADD;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= 32'd0;
            r_rsp_flags <= '0;
            r_apsr      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_op     <= req_opcode[w_idx];
                        r_a      <= req_a[w_idx];
                        r_b      <= req_b[w_idx];
                        r_cur_id <= w_idx;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_result;
                    r_rsp_flags <= w_flags;
                    r_rsp_id    <= r_cur_id;
                    r_apsr      <= w_flags;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_flags  = r_rsp_flags;
    assign apsr_flags = r_apsr;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed scoreboard bench for the round-robin ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NUM_REQ = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    alu_op_t [NUM_REQ-1:0]    req_opcode;
    logic [NUM_REQ-1:0][31:0] req_a;
    logic [NUM_REQ-1:0][31:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [0:0]               rsp_id;
    logic [31:0]              rsp_data;
    alu_flags_t               rsp_flags;
    alu_flags_t               apsr_flags;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .apsr_flags (apsr_flags)
    );

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] data;
        alu_flags_t  flags;
    } exp_t;

    exp_t sb[$];
    int   gq_id[$];
    int   gq_cyc[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   auto_drop = 1'b1;
    bit   granted;
    int   grant_id;
    bit   resp_popped;
    bit   lat_pending = 1'b0;
    int   lat_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model computes carry/overflow from wide integer arithmetic.
    function automatic exp_t model(input int id, input alu_op_t op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb_;
        longint      s;
        logic [63:0] u;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        e   = '0;
        r   = 32'd0;
        case (op)
            OP_ADD: begin
                u = {32'd0, a} + {32'd0, b};
                r = u[31:0];
                e.flags.c = (u > 64'h0000_0000_FFFF_FFFF);
                s = sa + sb_;
                e.flags.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                r = a - b;
                e.flags.c = (a >= b);
                s = sa - sb_;
                e.flags.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = 32'd0;
        endcase
        e.id      = 1'(id);
        e.data    = r;
        e.flags.n = r[31];
        e.flags.z = (r == 32'd0);
        return e;
    endfunction

    // One clock: sample mid-cycle, update scoreboard, advance past the edge.
    task automatic step();
        exp_t e;
        #3;
        granted     = 1'b0;
        resp_popped = 1'b0;
        chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sb.push_back(model(i, req_opcode[i], req_a[i], req_b[i]));
                granted  = 1'b1;
                grant_id = i;
                gq_id.push_back(i);
                gq_cyc.push_back(cyc);
                lat_cyc     = cyc;
                lat_pending = 1'b1;
            end
        end
        if (rsp_valid && lat_pending) begin
            chk("latency", 64'(cyc - lat_cyc), 64'd2);
            lat_pending = 1'b0;
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
            end
            resp_popped = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (granted && auto_drop) req_valid[grant_id] = 1'b0;
    endtask

    task automatic issue(input int i, input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        req_opcode[i] = op;
        req_a[i]      = a;
        req_b[i]      = b;
        req_valid[i]  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (granted && grant_id == i) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (resp_popped) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sb.delete();
        lat_pending = 1'b0;
    endtask

    initial begin
        alu_flags_t f_exp;
        rst        = 1'b1;
        req_valid  = '1;
        req_opcode = {OP_ADD, OP_ADD};
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        step();
        step();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        chk("rst_apsr", 64'(apsr_flags), 64'd0);
        req_valid = '0;
        rst       = 1'b0;
        sb.delete();
        lat_pending = 1'b0;

        // Single ADD with carry-out and zero result.
        issue(0, OP_ADD, 32'hFFFF_FFFF, 32'h1);
        chk("exec_no_valid", 64'(rsp_valid), 64'd0);
        chk("exec_no_ready", 64'(req_ready), 64'd0);
        wait_rsp();

        // Undefined opcode.
        issue(1, alu_op_t'(3'd7), 32'h1234, 32'h5678);
        wait_rsp();

        // Signed overflow, and apsr holds the flags while idle.
        issue(0, OP_ADD, 32'h7FFF_FFFF, 32'h1);
        wait_rsp();
        f_exp = '{n: 1'b1, z: 1'b0, c: 1'b0, v: 1'b1};
        chk("apsr_ovf", 64'(apsr_flags), 64'(f_exp));
        step();
        step();
        chk("apsr_hold", 64'(apsr_flags), 64'(f_exp));

        // Backpressure: response held stable, no grants while stalled.
        rsp_ready = 1'b0;
        issue(0, OP_SUB, 32'd5, 32'd7);
        req_opcode[1] = OP_OR;
        req_a[1]      = 32'hF0F0_0000;
        req_b[1]      = 32'h0000_0F0F;
        req_valid[1]  = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_data", 64'(rsp_data), 64'hFFFF_FFFE);
            chk("bp_n", 64'(rsp_flags.n), 64'd1);
            chk("bp_c", 64'(rsp_flags.c), 64'd0);
            chk("bp_no_ready", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        wait_rsp();
        wait_rsp();

        // Reset during EXEC discards the op and restores the pointer.
        issue(0, OP_ADD, 32'd0, 32'd0);
        wait_rsp();
        f_exp = '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};
        chk("apsr_pre_rst", 64'(apsr_flags), 64'(f_exp));
        issue(1, OP_XOR, 32'd3, 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        lat_pending = 1'b0;
        chk("midrst_no_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_apsr", 64'(apsr_flags), 64'd0);
        req_opcode = {OP_AND, OP_OR};
        req_a      = {32'hFF00_FF00, 32'h0000_00F0};
        req_b      = {32'h0F0F_0F0F, 32'h0000_000F};
        req_valid  = '1;
        step();
        chk("midrst_granted", 64'(granted), 64'd1);
        chk("midrst_grant0", 64'(grant_id), 64'd0);
        chk("midrst_still_no_valid", 64'(rsp_valid), 64'd0);
        wait_rsp();
        wait_rsp();

        // Contention from reset: grants alternate, 6-cycle period each.
        req_valid = '0;
        do_reset();
        gq_id.delete();
        gq_cyc.delete();
        auto_drop = 1'b0;
        req_opcode = {OP_XOR, OP_AND};
        req_a      = {32'hAAAA_5555, 32'h1234_5678};
        req_b      = {32'hFFFF_0000, 32'h0F0F_0F0F};
        req_valid  = '1;
        for (int k = 0; k < 12; k++) step();
        req_valid = '0;
        auto_drop = 1'b1;
        chk("cont_ngrants", 64'(gq_id.size()), 64'd4);
        if (gq_id.size() >= 4) begin
            chk("cont_g0", 64'(gq_id[0]), 64'd0);
            chk("cont_g1", 64'(gq_id[1]), 64'd1);
            chk("cont_g2", 64'(gq_id[2]), 64'd0);
            chk("cont_g3", 64'(gq_id[3]), 64'd1);
            chk("cont_period0", 64'(gq_cyc[2] - gq_cyc[0]), 64'd6);
            chk("cont_period1", 64'(gq_cyc[3] - gq_cyc[1]), 64'd6);
        end
        step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_arbiter
`default_nettype wire
